// File: rtl/aes_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM word port between NUM_REQ requesters
// that use the level-start / pulsed-complete handshake.
module aes_bram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 2
) (
    input  logic                      aes_clk,
    input  logic                      aes_rst,
    input  logic [NUM_REQ-1:0]        req_start_read,
    input  logic [NUM_REQ-1:0]        req_start_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_complete,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic                      bram_en,
    output logic [DATA_W/8-1:0]       bram_we,
    output logic [DATA_W-1:0]         bram_wdata,
    input  logic [DATA_W-1:0]         bram_rdata,
    output logic                      arb_busy,
    output logic [2:0]                arb_grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_q;
    logic [1:0]          lat_cnt;

    logic [7:0]          requesting;
    logic [2:0]          cand;
    logic [2:0]          pick;
    logic                found;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic                write_sel;

    // grant doubles as the round-robin pointer: search starts just past it
    always_comb begin
        requesting               = '0;
        requesting[NUM_REQ-1:0]  = req_start_read | req_start_write;
        found                    = 1'b0;
        pick                     = grant;
        cand                     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 3'((int'(grant) + k) % NUM_REQ);
            if (!found && requesting[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        write_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 3'(i)) begin
                addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
                wdata_sel = req_wdata[i*DATA_W +: DATA_W];
                write_sel = req_start_write[i];
            end
        end
    end

    always_ff @(posedge aes_clk) begin
        if (aes_rst) begin
            state     <= IDLE;
            grant     <= 3'(NUM_REQ - 1);
            lat_cnt   <= '0;
            req_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= pick;
                        addr_q  <= addr_sel;
                        wdata_q <= wdata_sel;
                        write_q <= write_sel;
                    end
                end
                ISSUE: begin
                    if (!write_q) begin
                        lat_cnt <= 2'(RD_LAT - 1);
                        if (RD_LAT == 1) req_rdata <= bram_rdata;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) req_rdata <= bram_rdata;
                    else                 lat_cnt   <= lat_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = (write_q || RD_LAT == 1) ? DONE : WAIT;
            WAIT:    if (lat_cnt == 2'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // BRAM strobes are decoded from state so every bram_* output is zero outside ISSUE
    assign bram_en      = (state == ISSUE);
    assign bram_addr    = bram_en ? addr_q : '0;
    assign bram_we      = (bram_en && write_q) ? '1 : '0;
    assign bram_wdata   = (bram_en && write_q) ? wdata_q : '0;
    assign req_complete = (state == DONE) ? (NUM_REQ'(1) << grant) : '0;
    assign arb_busy     = (state != IDLE);
    assign arb_grant    = grant;

endmodule

// File: tb/tb_aes_bram_arbiter.sv
// Bench for aes_bram_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_aes_bram_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int RD_LAT  = 2;

    logic                      aes_clk = 1'b0;
    logic                      aes_rst = 1'b1;
    logic [NUM_REQ-1:0]        req_start_read  = '0;
    logic [NUM_REQ-1:0]        req_start_write = '0;
    logic [31:0]               drv_addr  [NUM_REQ];
    logic [31:0]               drv_wdata [NUM_REQ];
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_complete;
    logic [DATA_W-1:0]         req_rdata;
    logic [ADDR_W-1:0]         bram_addr;
    logic                      bram_en;
    logic [DATA_W/8-1:0]       bram_we;
    logic [DATA_W-1:0]         bram_wdata;
    logic [DATA_W-1:0]         bram_rdata;
    logic                      arb_busy;
    logic [2:0]                arb_grant;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 aes_clk = ~aes_clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = drv_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = drv_wdata[i];
        end
    end

    aes_bram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .aes_clk(aes_clk), .aes_rst(aes_rst),
        .req_start_read(req_start_read), .req_start_write(req_start_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_complete(req_complete), .req_rdata(req_rdata),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .arb_busy(arb_busy), .arb_grant(arb_grant)
    );

    function automatic bit [31:0] init_val(input int idx);
        if (idx == 17) return 32'h12345678;
        return 32'hC0DE0000 ^ 32'(idx * 32'h00010203);
    endfunction

    // BRAM with a two-cycle read pipeline and unwritten words from init_val
    bit [31:0] env_mem [256];
    bit        env_wr  [256];
    bit [31:0] s1, s2;
    logic [7:0] bidx;
    assign bidx       = bram_addr[9:2];
    assign bram_rdata = s2;
    always @(posedge aes_clk) begin
        if (bram_en) begin
            if (bram_we == 4'hF) begin
                env_mem[bidx] <= bram_wdata;
                env_wr[bidx]  <= 1'b1;
            end else begin
                s1 <= env_wr[bidx] ? env_mem[bidx] : init_val(int'(bidx));
            end
        end
        s2 <= s1;
    end

    // Reference model: phase = cycles since the grant decision, -1 when idle
    int         m_phase = -1;
    logic [2:0] m_grant = 3'(NUM_REQ - 1);
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    bit         m_write = 1'b0;
    bit [31:0]  ref_mem [256];
    bit         ref_wr  [256];

    function automatic int m_last();
        return m_write ? 2 : RD_LAT + 2;
    endfunction

    always @(posedge aes_clk) begin : model
        int base, j;
        bit got;
        if (m_phase == 1 && m_write) begin
            ref_mem[m_addr[9:2]] = m_wdata;
            ref_wr[m_addr[9:2]]  = 1'b1;
        end
        if (aes_rst) begin
            m_phase = -1;
            m_grant = 3'(NUM_REQ - 1);
            m_rdata = '0;
        end else if (m_phase == -1) begin
            got  = 1'b0;
            base = int'(m_grant);
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (base + k) % NUM_REQ;
                if (!got && (req_start_read[j] || req_start_write[j])) begin
                    got     = 1'b1;
                    m_grant = 3'(j);
                    m_write = req_start_write[j];
                    m_addr  = drv_addr[j];
                    m_wdata = drv_wdata[j];
                    m_phase = 1;
                end
            end
        end else if (m_phase == m_last()) begin
            m_phase = -1;
        end else begin
            m_phase++;
            if (!m_write && m_phase == m_last())
                m_rdata = ref_wr[m_addr[9:2]] ? ref_mem[m_addr[9:2]] : init_val(int'(m_addr[9:2]));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aes_clk) begin
        if (chk_en) begin
            bit issue, wr_issue;
            issue    = (m_phase == 1);
            wr_issue = issue && m_write;
            check("cmp_busy",   64'(arb_busy),     64'(m_phase != -1));
            check("cmp_grant",  64'(arb_grant),    64'(m_grant));
            check("cmp_en",     64'(bram_en),      64'(issue));
            check("cmp_we",     64'(bram_we),      wr_issue ? 64'hF : 64'h0);
            check("cmp_addr",   64'(bram_addr),    issue ? 64'(m_addr) : 64'h0);
            check("cmp_wdata",  64'(bram_wdata),   wr_issue ? 64'(m_wdata) : 64'h0);
            check("cmp_cpl",    64'(req_complete), (m_phase != -1 && m_phase == m_last()) ? (64'(1) << m_grant) : 64'h0);
            check("cmp_rdata",  64'(req_rdata),    64'(m_rdata));
        end
    end

    task automatic step();
        @(posedge aes_clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        aes_rst = 1'b1;
        step();
        aes_rst = 1'b0;
    endtask

    task automatic single(input int i, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input logic [3:0] exp_we,
                          output logic [31:0] rdata_at_cpl);
        int cyc, when;
        when = -1;
        cyc  = 0;
        rdata_at_cpl = '0;
        step();
        req_start_read[i]  = rd;
        req_start_write[i] = wr;
        drv_addr[i]        = a;
        drv_wdata[i]       = d;
        while (cyc < 12 && when < 0) begin
            @(negedge aes_clk);
            if (cyc == 1) begin
                check("single_en",   64'(bram_en),   64'h1);
                check("single_we",   64'(bram_we),   64'(exp_we));
                check("single_addr", 64'(bram_addr), 64'(a));
                if (wr) check("single_wdata", 64'(bram_wdata), 64'(d));
            end
            if (req_complete != '0) begin
                when = cyc;
                check("single_cpl_bits", 64'(req_complete), 64'(1) << i);
                rdata_at_cpl = req_rdata;
            end else begin
                step();
                cyc++;
            end
        end
        check("single_latency", 64'(when), 64'(exp_lat));
        step();
        req_start_read[i]  = 1'b0;
        req_start_write[i] = 1'b0;
    endtask

    int log_id[$];
    int log_cyc[$];

    // mode 0: random traffic with rare resets; 1: every requester always writes; 2: no new requests
    task automatic run_traffic(input int cycles, input int mode);
        bit [NUM_REQ-1:0] fin;
        int kind;
        fin = '0;
        log_id.delete();
        log_cyc.delete();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (mode == 0) aes_rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fin[i]) begin
                    req_start_read[i]  = 1'b0;
                    req_start_write[i] = 1'b0;
                    fin[i] = 1'b0;
                end else if (!req_start_read[i] && !req_start_write[i]) begin
                    if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
                        kind = (mode == 1) ? 1 : int'($urandom_range(0, 2));
                        drv_addr[i]        = $urandom;
                        drv_wdata[i]       = $urandom;
                        req_start_read[i]  = (kind != 1);
                        req_start_write[i] = (kind != 0);
                    end
                end
            end
            @(negedge aes_clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_complete[i]) begin
                    fin[i] = 1'b1;
                    log_id.push_back(i);
                    log_cyc.push_back(c);
                end
            end
        end
        step();
        req_start_read  = '0;
        req_start_write = '0;
        aes_rst = 1'b1;
        step();
        aes_rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd_val;
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_addr[i]  = '0;
            drv_wdata[i] = '0;
        end
        aes_rst = 1'b1;
        step();
        chk_en = 1'b1;
        @(negedge aes_clk);
        check("rst_grant", 64'(arb_grant),    64'(NUM_REQ - 1));
        check("rst_busy",  64'(arb_busy),     64'h0);
        check("rst_en",    64'(bram_en),      64'h0);
        check("rst_rdata", 64'(req_rdata),    64'h0);
        check("rst_cpl",   64'(req_complete), 64'h0);
        step();
        aes_rst = 1'b0;

        single(1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 2, 4'hF, rd_val);
        @(negedge aes_clk);
        check("wr_grant_hold", 64'(arb_grant), 64'h1);

        single(0, 1'b1, 1'b0, 32'h44, 32'h0, 4, 4'h0, rd_val);
        check("rd_value", 64'(rd_val), 64'h12345678);

        do_reset();
        step();
        drv_addr[0] = 32'h48;  req_start_read[0]  = 1'b1;
        drv_addr[1] = 32'h4C;  drv_wdata[1] = 32'h0BADF00D;  req_start_write[1] = 1'b1;
        run_traffic(10, 2);
        check("cont_count", 64'(log_id.size()), 64'h2);
        if (log_id.size() == 2) begin
            check("cont_first",  64'(log_id[0]),  64'h0);
            check("cont_second", 64'(log_id[1]),  64'h1);
            check("cont_cyc0",   64'(log_cyc[0]), 64'h3);
            check("cont_cyc1",   64'(log_cyc[1]), 64'h6);
        end

        do_reset();
        run_traffic(28, 1);
        check("rr_count", 64'(log_id.size() >= 9), 64'h1);
        for (int k = 0; k < 9 && k < log_id.size(); k++) begin
            check("rr_grant", 64'(log_id[k]),  64'(k % 3));
            check("rr_cycle", 64'(log_cyc[k]), 64'(2 + 3 * k));
        end

        do_reset();
        step();
        drv_addr[0] = 32'h50;
        req_start_read[0] = 1'b1;
        step();
        step();
        aes_rst = 1'b1;
        req_start_read[0] = 1'b0;
        step();
        aes_rst = 1'b0;
        @(negedge aes_clk);
        check("midrst_busy", 64'(arb_busy), 64'h0);
        check("midrst_en",   64'(bram_en),  64'h0);
        repeat (6) begin
            step();
            @(negedge aes_clk);
            check("midrst_no_cpl", 64'(req_complete), 64'h0);
        end
        single(0, 1'b1, 1'b0, 32'h50, 32'h0, 4, 4'h0, rd_val);
        check("midrst_rd_value", 64'(rd_val), 64'(init_val(20)));

        single(0, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 2, 4'hF, rd_val);
        check("rw_rdata_kept", 64'(rd_val), 64'(init_val(20)));

        run_traffic(600, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
